// File: rtl/pip_flush_ctrl_if.sv
// Pipeline flush/redirect bundle driven by the flush controller toward fetch and the BPU.
`ifndef XLEN
`define XLEN 64
`endif

interface pip_flush_interface #(
  parameter int XLEN = `XLEN
);
  logic [XLEN-1:0] newpc;
  logic            flush;
  logic            hold;
  logic            flushbpu;

  modport master (output newpc, output flush, output hold, output flushbpu);
  modport slave  (input  newpc, input  flush, input  hold, input  flushbpu);
endinterface

// File: rtl/pip_flush_ctrl.sv
// Arbitrates commit/decode redirects into one-cycle flush pulses and sequences
// fence.i / sfence.vma maintenance with the front end held.
//
// state    | meaning
// ---------|---------------------------------------------------------------
// IDLE     | accepting redirects; commit wins over decode
// CMO_WAIT | front end held, cache/TLB maintenance requested, awaiting ack
// RELEASE  | one cycle: flush to the latched target, hold dropped
`ifndef XLEN
`define XLEN 64
`endif

module pip_flush_ctrl #(
  parameter int XLEN = `XLEN
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               cmt_redir_valid_i,
  input  logic [XLEN-1:0]    cmt_redir_pc_i,
  input  logic [1:0]         cmt_redir_type_i,
  input  logic               dec_redir_valid_i,
  input  logic [XLEN-1:0]    dec_redir_pc_i,
  input  logic               cmo_ack_i,
  output logic               cmo_req_o,
  output logic               cmo_type_o,
  output logic               busy_o,
  pip_flush_interface.master flush_if
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_CMO_WAIT = 2'd1,
    S_RELEASE  = 2'd2
  } state_e;

  localparam logic [XLEN-1:0] PC_MASK = ~XLEN'(1);

  state_e          state_q, state_d;
  logic [XLEN-1:0] tgt_q, tgt_d;
  logic [XLEN-1:0] newpc_q, newpc_d;
  logic            flush_q, flush_d;
  logic            fbpu_q, fbpu_d;
  logic            hold_q, hold_d;
  logic            cmo_req_q, cmo_req_d;
  logic            cmo_type_q, cmo_type_d;

  logic [XLEN-1:0] cmt_pc_even;
  logic [XLEN-1:0] dec_pc_even;

  assign cmt_pc_even = cmt_redir_pc_i & PC_MASK;
  assign dec_pc_even = dec_redir_pc_i & PC_MASK;

  always_comb begin
    state_d    = state_q;
    tgt_d      = tgt_q;
    newpc_d    = newpc_q;
    flush_d    = 1'b0;
    fbpu_d     = 1'b0;
    cmo_type_d = cmo_type_q;
    unique case (state_q)
      S_IDLE: begin
        if (cmt_redir_valid_i) begin
          flush_d = 1'b1;
          newpc_d = cmt_pc_even;
          fbpu_d  = (cmt_redir_type_i != 2'd0);
          // Types 2/3 are maintenance ops: park the target until the ack returns.
          if (cmt_redir_type_i[1]) begin
            state_d    = S_CMO_WAIT;
            tgt_d      = cmt_pc_even;
            cmo_type_d = cmt_redir_type_i[0];
          end
        end else if (dec_redir_valid_i) begin
          flush_d = 1'b1;
          newpc_d = dec_pc_even;
        end
      end
      S_CMO_WAIT: begin
        if (cmo_ack_i) begin
          state_d    = S_RELEASE;
          flush_d    = 1'b1;
          newpc_d    = tgt_q;
          cmo_type_d = 1'b0;
        end
      end
      S_RELEASE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // hold and cmo_req share one source so a request can never appear unheld.
    hold_d    = (state_d == S_CMO_WAIT);
    cmo_req_d = (state_d == S_CMO_WAIT);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q    <= S_IDLE;
      tgt_q      <= '0;
      newpc_q    <= '0;
      flush_q    <= 1'b0;
      fbpu_q     <= 1'b0;
      hold_q     <= 1'b0;
      cmo_req_q  <= 1'b0;
      cmo_type_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tgt_q      <= tgt_d;
      newpc_q    <= newpc_d;
      flush_q    <= flush_d;
      fbpu_q     <= fbpu_d;
      hold_q     <= hold_d;
      cmo_req_q  <= cmo_req_d;
      cmo_type_q <= cmo_type_d;
    end
  end

  assign flush_if.newpc    = newpc_q;
  assign flush_if.flush    = flush_q;
  assign flush_if.hold     = hold_q;
  assign flush_if.flushbpu = fbpu_q;
  assign cmo_req_o         = cmo_req_q;
  assign cmo_type_o        = cmo_type_q;
  assign busy_o            = (state_q != S_IDLE);

endmodule

// File: tb/tb_pip_flush_ctrl.sv
// Scenario bench for pip_flush_ctrl: each task queues expected outputs as it drives
// a cycle and pops/compares them one clock later.
`ifndef XLEN
`define XLEN 64
`endif

module tb_pip_flush_ctrl;
  localparam int XLEN = `XLEN;

  typedef struct packed {
    logic            rst_n;
    logic            cv;
    logic [1:0]      ct;
    logic [XLEN-1:0] cpc;
    logic            dv;
    logic [XLEN-1:0] dpc;
    logic            ack;
  } stim_t;

  typedef struct packed {
    logic            flush;
    logic            fbpu;
    logic            hold;
    logic            req;
    logic            typ;
    logic            busy;
    logic [XLEN-1:0] pc;
  } out_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n = 1'b0;
  logic            cv = 1'b0, dv = 1'b0, ack = 1'b0;
  logic [1:0]      ct = '0;
  logic [XLEN-1:0] cpc = '0, dpc = '0;
  logic            req, typ, busy;

  pip_flush_interface #(.XLEN(XLEN)) fif ();

  pip_flush_ctrl #(.XLEN(XLEN)) dut (
    .clk_i             (clk),
    .rst_n_i           (rst_n),
    .cmt_redir_valid_i (cv),
    .cmt_redir_pc_i    (cpc),
    .cmt_redir_type_i  (ct),
    .dec_redir_valid_i (dv),
    .dec_redir_pc_i    (dpc),
    .cmo_ack_i         (ack),
    .cmo_req_o         (req),
    .cmo_type_o        (typ),
    .busy_o            (busy),
    .flush_if          (fif)
  );

  int   n_vec = 0;
  int   n_err = 0;
  out_t exp_q[$];

  function automatic stim_t s(logic r, logic c, logic [1:0] t, logic [XLEN-1:0] cp,
                              logic d, logic [XLEN-1:0] dp, logic a);
    stim_t v;
    v = '{r, c, t, cp, d, dp, a};
    return v;
  endfunction

  function automatic out_t o(logic f, logic b, logic h, logic rq, logic ty, logic bz,
                             logic [XLEN-1:0] pc);
    out_t v;
    v = '{f, b, h, rq, ty, bz, pc};
    return v;
  endfunction

  function automatic out_t observe();
    out_t v;
    v = '{fif.flush, fif.flushbpu, fif.hold, req, typ, busy, fif.newpc};
    return v;
  endfunction

  task automatic apply(input stim_t v);
    rst_n = v.rst_n; cv = v.cv; ct = v.ct; cpc = v.cpc;
    dv = v.dv; dpc = v.dpc; ack = v.ack;
  endtask

  stim_t RST, IDL, ACK;
  out_t  ZERO;

  // cmo_req without hold is never legal, whatever the scenario.
  always @(negedge clk) begin
    if (req === 1'b1 && fif.hold !== 1'b1) begin
      n_err++;
      $display("FAIL req_without_hold at %0t: req=%b hold=%b", $time, req, fif.hold);
    end
  end

  task automatic test_reset();
    stim_t st[$]; out_t ex[$]; out_t e, ob;
    st.push_back(s(0, 1, 2'd2, 'h1234, 1, 'h55, 1)); ex.push_back(ZERO);
    st.push_back(IDL);                              ex.push_back(ZERO);
    st.push_back(ACK);                              ex.push_back(ZERO);
    foreach (st[i]) begin
      apply(st[i]); exp_q.push_back(ex[i]);
      @(negedge clk); e = exp_q.pop_front(); ob = observe(); n_vec++;
      if (ob !== e) begin n_err++; $display("FAIL reset[%0d] got %h expected %h", i, ob, e); end
    end
  endtask

  task automatic test_mispredict();
    stim_t st[$]; out_t ex[$]; out_t e, ob;
    st.push_back(RST);                                 ex.push_back(ZERO);
    st.push_back(s(1, 1, 2'd0, 'h8000_1002, 0, 0, 0)); ex.push_back(o(1, 0, 0, 0, 0, 0, 'h8000_1002));
    st.push_back(IDL);                                 ex.push_back(o(0, 0, 0, 0, 0, 0, 'h8000_1002));
    st.push_back(s(1, 1, 2'd1, 'h8000_0007, 0, 0, 0)); ex.push_back(o(1, 1, 0, 0, 0, 0, 'h8000_0006));
    st.push_back(IDL);                                 ex.push_back(o(0, 0, 0, 0, 0, 0, 'h8000_0006));
    foreach (st[i]) begin
      apply(st[i]); exp_q.push_back(ex[i]);
      @(negedge clk); e = exp_q.pop_front(); ob = observe(); n_vec++;
      if (ob !== e) begin n_err++; $display("FAIL mispredict[%0d] got %h expected %h", i, ob, e); end
    end
  endtask

  task automatic test_fence_i();
    stim_t st[$]; out_t ex[$]; out_t e, ob;
    st.push_back(RST);                                 ex.push_back(ZERO);
    st.push_back(s(1, 1, 2'd2, 'h8000_2001, 0, 0, 0)); ex.push_back(o(1, 1, 1, 1, 0, 1, 'h8000_2000));
    for (int k = 0; k < 4; k++) begin
      st.push_back(IDL);                               ex.push_back(o(0, 0, 1, 1, 0, 1, 'h8000_2000));
    end
    st.push_back(ACK);                                 ex.push_back(o(1, 0, 0, 0, 0, 1, 'h8000_2000));
    st.push_back(IDL);                                 ex.push_back(o(0, 0, 0, 0, 0, 0, 'h8000_2000));
    foreach (st[i]) begin
      apply(st[i]); exp_q.push_back(ex[i]);
      @(negedge clk); e = exp_q.pop_front(); ob = observe(); n_vec++;
      if (ob !== e) begin n_err++; $display("FAIL fence_i[%0d] got %h expected %h", i, ob, e); end
    end
  endtask

  task automatic test_collision();
    stim_t st[$]; out_t ex[$]; out_t e, ob;
    st.push_back(RST);                              ex.push_back(ZERO);
    st.push_back(s(1, 1, 2'd1, 'h100, 1, 'h200, 0)); ex.push_back(o(1, 1, 0, 0, 0, 0, 'h100));
    st.push_back(IDL);                              ex.push_back(o(0, 0, 0, 0, 0, 0, 'h100));
    st.push_back(ACK);                              ex.push_back(o(0, 0, 0, 0, 0, 0, 'h100));
    foreach (st[i]) begin
      apply(st[i]); exp_q.push_back(ex[i]);
      @(negedge clk); e = exp_q.pop_front(); ob = observe(); n_vec++;
      if (ob !== e) begin n_err++; $display("FAIL collision[%0d] got %h expected %h", i, ob, e); end
    end
  endtask

  task automatic test_busy_ignore();
    stim_t st[$]; out_t ex[$]; out_t e, ob;
    st.push_back(RST);                               ex.push_back(ZERO);
    st.push_back(s(1, 1, 2'd3, 'h1000, 0, 0, 0));    ex.push_back(o(1, 1, 1, 1, 1, 1, 'h1000));
    st.push_back(s(1, 0, 2'd0, 0, 1, 'h300, 0));     ex.push_back(o(0, 0, 1, 1, 1, 1, 'h1000));
    st.push_back(s(1, 1, 2'd0, 'h700, 0, 0, 0));     ex.push_back(o(0, 0, 1, 1, 1, 1, 'h1000));
    st.push_back(ACK);                               ex.push_back(o(1, 0, 0, 0, 0, 1, 'h1000));
    st.push_back(s(1, 0, 2'd0, 0, 1, 'h300, 0));     ex.push_back(o(0, 0, 0, 0, 0, 0, 'h1000));
    st.push_back(IDL);                               ex.push_back(o(0, 0, 0, 0, 0, 0, 'h1000));
    foreach (st[i]) begin
      apply(st[i]); exp_q.push_back(ex[i]);
      @(negedge clk); e = exp_q.pop_front(); ob = observe(); n_vec++;
      if (ob !== e) begin n_err++; $display("FAIL busy_ignore[%0d] got %h expected %h", i, ob, e); end
    end
  endtask

  task automatic test_reset_mid_cmo();
    stim_t st[$]; out_t ex[$]; out_t e, ob;
    st.push_back(RST);                            ex.push_back(ZERO);
    st.push_back(s(1, 1, 2'd3, 'h2000, 0, 0, 0)); ex.push_back(o(1, 1, 1, 1, 1, 1, 'h2000));
    st.push_back(IDL);                            ex.push_back(o(0, 0, 1, 1, 1, 1, 'h2000));
    st.push_back(RST);                            ex.push_back(ZERO);
    st.push_back(ACK);                            ex.push_back(ZERO);
    st.push_back(IDL);                            ex.push_back(ZERO);
    foreach (st[i]) begin
      apply(st[i]); exp_q.push_back(ex[i]);
      @(negedge clk); e = exp_q.pop_front(); ob = observe(); n_vec++;
      if (ob !== e) begin n_err++; $display("FAIL reset_mid_cmo[%0d] got %h expected %h", i, ob, e); end
    end
  endtask

  task automatic test_back_to_back();
    stim_t st[$]; out_t ex[$]; out_t e, ob;
    st.push_back(RST);                           ex.push_back(ZERO);
    st.push_back(s(1, 0, 2'd0, 0, 1, 'h400, 0)); ex.push_back(o(1, 0, 0, 0, 0, 0, 'h400));
    st.push_back(s(1, 1, 2'd0, 'h500, 0, 0, 0)); ex.push_back(o(1, 0, 0, 0, 0, 0, 'h500));
    st.push_back(s(1, 0, 2'd0, 0, 1, 'h601, 0)); ex.push_back(o(1, 0, 0, 0, 0, 0, 'h600));
    st.push_back(IDL);                           ex.push_back(o(0, 0, 0, 0, 0, 0, 'h600));
    foreach (st[i]) begin
      apply(st[i]); exp_q.push_back(ex[i]);
      @(negedge clk); e = exp_q.pop_front(); ob = observe(); n_vec++;
      if (ob !== e) begin n_err++; $display("FAIL back_to_back[%0d] got %h expected %h", i, ob, e); end
    end
  endtask

  initial begin
    RST  = s(0, 0, 2'd0, 0, 0, 0, 0);
    IDL  = s(1, 0, 2'd0, 0, 0, 0, 0);
    ACK  = s(1, 0, 2'd0, 0, 0, 0, 1);
    ZERO = o(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    test_reset();
    test_mispredict();
    test_fence_i();
    test_collision();
    test_busy_ignore();
    test_reset_mid_cmo();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pip_flush_ctrl.md
PIP_FLUSH_CTRL -- requirements
Module: pip_flush_ctrl

Interface
REQ-001 SHALL have parameter XLEN, default 64, meaning the PC width; it SHALL match `XLEN.
REQ-002 SHALL have port clk_i, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-003 SHALL have port rst_n_i, input, 1, reset; it SHALL be synchronous and active-low.
REQ-004 SHALL have port cmt_redir_valid_i, input, 1, commit-stage redirect request.
REQ-005 SHALL have port cmt_redir_pc_i, input, XLEN, commit-stage redirect target.
REQ-006 SHALL have port cmt_redir_type_i, input, 2, redirect type: 0=mispredict, 1=trap/xret, 2=fence.i, 3=sfence.vma.
REQ-007 SHALL have port dec_redir_valid_i, input, 1, decode-stage early redirect request (JAL).
REQ-008 SHALL have port dec_redir_pc_i, input, XLEN, decode-stage redirect target.
REQ-009 SHALL have port cmo_ack_i, input, 1, cache/TLB maintenance done, single-cycle pulse.
REQ-010 SHALL have port cmo_req_o, output, 1, cache/TLB maintenance request, level.
REQ-011 SHALL have port cmo_type_o, output, 1, 0=fence.i (icache), 1=sfence.vma (TLB).
REQ-012 SHALL have port busy_o, output, 1, high whenever state is not IDLE.
REQ-013 SHALL have master modport of pip_flush_interface driving newpc (XLEN), flush, hold and flushbpu, all registered.

Function
REQ-014 SHALL implement FSM states IDLE, CMO_WAIT, RELEASE.
REQ-015 In IDLE, with cmt_redir_valid_i and type 0 or 1, SHALL assert flush for exactly one cycle, starting the cycle after the request, with newpc = cmt_redir_pc_i; state SHALL remain IDLE.
REQ-016 flushbpu SHALL pulse alongside flush for type 1, 2 and 3; it SHALL stay low for type 0 and for decode redirects.
REQ-017 In IDLE, with cmt_redir_valid_i and type 2 or 3, SHALL latch the target, assert flush and flushbpu for one cycle, and enter CMO_WAIT.
REQ-018 In CMO_WAIT, hold SHALL be 1 and cmo_req_o SHALL be 1 with cmo_type_o = type[0].
REQ-019 In CMO_WAIT, on cmo_ack_i, SHALL deassert cmo_req_o the next cycle and enter RELEASE.
REQ-020 RELEASE SHALL last one cycle: flush=1, newpc = latched target, hold=0 (hold SHALL drop in this cycle), then return to IDLE.
REQ-021 In IDLE, dec_redir_valid_i alone SHALL produce a one-cycle flush with newpc = dec_redir_pc_i and flushbpu=0.
REQ-022 If commit and decode requests coincide, the commit request SHALL win and the decode request SHALL be dropped.
REQ-023 All redirect inputs SHALL be ignored while not in IDLE; cmo_ack_i SHALL be ignored outside CMO_WAIT.
REQ-024 newpc bit 0 SHALL be forced to 0; the remaining bits SHALL pass unchanged.
REQ-025 newpc SHALL hold its last value when flush=0.
REQ-026 Back-to-back IDLE requests in consecutive cycles SHALL each produce their own one-cycle flush pulse, with no merge and no bubble.
REQ-027 cmo_req_o SHALL never assert without hold=1 in the same cycle.

Reset
REQ-028 With rst_n_i=0 at a clock edge: state=IDLE; newpc=0; flush, hold, flushbpu, cmo_req_o, cmo_type_o and busy_o all 0.
REQ-029 Reset during CMO_WAIT or RELEASE SHALL abort the operation; cmo_req_o and hold SHALL read 0 from the cycle after the reset edge, and no RELEASE flush SHALL be issued.
REQ-030 A redirect request present while rst_n_i=0 SHALL be discarded.

Verification
REQ-031 Mispredict: cmt valid, type 0, pc 0x8000_1002 in cycle N -> cycle N+1 flush=1, newpc=0x8000_1002, flushbpu=0, hold=0; cycle N+2 flush=0.
REQ-032 fence.i: type 2, pc 0x8000_2001, cmo_ack_i in cycle N+5 -> N+1: flush=1, flushbpu=1, hold=1, cmo_req_o=1, cmo_type_o=0; N+2..N+5: hold=1, flush=0; N+6: flush=1, newpc=0x8000_2000, hold=0, cmo_req_o=0; N+7: busy_o=0.
REQ-033 Collision: cmt type 1 pc 0x100 and dec pc 0x200 in the same cycle -> a single flush with newpc=0x100 and flushbpu=1; no flush to 0x200 follows.
REQ-034 Ignore while busy: dec redirect pc 0x300 during CMO_WAIT -> no flush until RELEASE; RELEASE newpc equals the latched CMO target.
REQ-035 Reset mid-CMO: sfence.vma, then rst_n_i=0 for 1 cycle during CMO_WAIT, then cmo_ack_i -> all outputs 0 after reset; the ack is ignored; no flush occurs.
REQ-036 Back-to-back: dec pc 0x400 in cycle N, cmt type 0 pc 0x500 in cycle N+1 -> flush in N+1 (0x400) and N+2 (0x500).
